// File: rtl/clk_div_bank.sv
// clk_div_bank: bank of independently configurable clock dividers with deferred reconfiguration and global phase restart
module clk_div_bank #(
  parameter int NUM_CH = 4,
  parameter int WIDTH = 16,
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              pl_clk,
  input  logic              pl_resetn,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [WIDTH-1:0]  cfg_div,
  input  logic              cfg_mode,
  input  logic              sync_restart,
  output logic [NUM_CH-1:0] div_out,
  output logic [NUM_CH-1:0] active
);
  typedef enum logic [1:0] {IDLE, RUN, PEND} state_t;
  logic [NUM_CH-1:0] w_sel;
  logic [NUM_CH-1:0] w_pend;
  // Out-of-range channel selects match no channel, so they are always ready and then dropped.
  assign cfg_ready = ~|(w_sel & w_pend);
  genvar i;
  for (i = 0; i < NUM_CH; i++) begin : g_ch
    state_t           r_st, w_st_n;
    logic [WIDTH-1:0] r_cnt, r_div, r_pdiv, w_cnt_n, w_div_n, w_pdiv_n;
    logic             r_mode, r_pmode, r_out, w_mode_n, w_pmode_n, w_out_n;
    logic             w_acc, w_term;
    assign w_sel[i]   = cfg_ch == CH_W'(i);
    assign w_pend[i]  = r_st == PEND;
    assign w_acc      = cfg_valid && cfg_ready && w_sel[i];
    assign w_term     = r_cnt == r_div - WIDTH'(1);
    assign div_out[i] = r_out;
    assign active[i]  = r_st != IDLE;
    // Channel state register; reset discards any pending reconfiguration.
    always_ff @(posedge pl_clk or negedge pl_resetn) begin
      if (!pl_resetn) begin
        r_st    <= IDLE;
        r_cnt   <= '0;
        r_div   <= '0;
        r_pdiv  <= '0;
        r_mode  <= 1'b0;
        r_pmode <= 1'b0;
        r_out   <= 1'b0;
      end else begin
        r_st    <= w_st_n;
        r_cnt   <= w_cnt_n;
        r_div   <= w_div_n;
        r_pdiv  <= w_pdiv_n;
        r_mode  <= w_mode_n;
        r_pmode <= w_pmode_n;
        r_out   <= w_out_n;
      end
    end
    // Next state: restart beats everything, idle channels load directly, running channels count and defer reconfiguration to the terminal count.
    always_comb begin
      w_st_n    = r_st;
      w_cnt_n   = r_cnt;
      w_div_n   = r_div;
      w_pdiv_n  = r_pdiv;
      w_mode_n  = r_mode;
      w_pmode_n = r_pmode;
      w_out_n   = r_out;
      if (sync_restart) begin
        w_cnt_n = '0;
        w_out_n = 1'b0;
        if (w_acc) begin
          w_div_n  = cfg_div;
          w_mode_n = cfg_mode;
          w_st_n   = (cfg_div != '0) ? RUN : IDLE;
        end else if (r_st == PEND) begin
          w_div_n  = r_pdiv;
          w_mode_n = r_pmode;
          w_st_n   = (r_pdiv != '0) ? RUN : IDLE;
        end
      end else if (r_st == IDLE) begin
        if (w_acc) begin
          w_div_n  = cfg_div;
          w_mode_n = cfg_mode;
          w_cnt_n  = '0;
          w_out_n  = 1'b0;
          w_st_n   = (cfg_div != '0) ? RUN : IDLE;
        end
      end else begin
        w_cnt_n = w_term ? '0 : r_cnt + WIDTH'(1);
        w_out_n = r_mode ? w_term : (r_out ^ w_term);
        if (w_acc) begin
          w_pdiv_n  = cfg_div;
          w_pmode_n = cfg_mode;
          w_st_n    = PEND;
        end else if (r_st == PEND && w_term) begin
          w_div_n  = r_pdiv;
          w_mode_n = r_pmode;
          w_st_n   = (r_pdiv != '0) ? RUN : IDLE;
          w_out_n  = (r_pdiv == '0 || r_pmode != r_mode) ? 1'b0 : w_out_n;
        end
      end
    end
  end
endmodule

// File: tb/tb_clk_div_bank.sv
// tb_clk_div_bank: scoreboard bench for clk_div_bank using closed-form divider output expectations
module tb_clk_div_bank;
  localparam int NC = 5;
  localparam int W  = 4;
  localparam int CW = 3;
  logic          pl_clk = 1'b0;
  logic          pl_resetn = 1'b0;
  logic          cfg_valid = 1'b0;
  logic          cfg_ready;
  logic [CW-1:0] cfg_ch = '0;
  logic [W-1:0]  cfg_div = '0;
  logic          cfg_mode = 1'b0;
  logic          sync_restart = 1'b0;
  logic [NC-1:0] div_out;
  logic [NC-1:0] active;
  int total = 0;
  int bad = 0;
  int cyc = 0;
  int base[NC];
  int n[NC];
  int sw_t[NC];
  int sw_n[NC];
  bit md[NC];
  bit on[NC];
  bit sw_m[NC];
  bit sw_o[NC];
  typedef struct {
    int            t;
    logic [NC-1:0] o;
    logic [NC-1:0] a;
  } exp_t;
  exp_t sbq[$];

  clk_div_bank #(.NUM_CH(NC), .WIDTH(W)) dut (
    .pl_clk(pl_clk),
    .pl_resetn(pl_resetn),
    .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready),
    .cfg_ch(cfg_ch),
    .cfg_div(cfg_div),
    .cfg_mode(cfg_mode),
    .sync_restart(sync_restart),
    .div_out(div_out),
    .active(active)
  );

  always #5 pl_clk = ~pl_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%0h want=%0h", tag, cyc, got, exp);
    end
  endtask

  // Square: level flips every nn cycles from 0; strobe: high on each multiple of nn after the start edge.
  function automatic bit f(input bit m, input int nn, input int k);
    return m ? (k > 0 && k % nn == 0) : ((k / nn) % 2 == 1);
  endfunction

  task automatic push();
    exp_t e;
    e.t = cyc + 1;
    e.o = '0;
    e.a = '0;
    for (int c = 0; c < NC; c++) begin
      if (on[c] && sw_t[c] == e.t) begin
        base[c] = e.t;
        n[c] = sw_n[c];
        md[c] = sw_m[c];
        on[c] = sw_n[c] != 0;
        e.o[c] = sw_o[c];
        e.a[c] = on[c];
        sw_t[c] = -1;
      end else if (on[c]) begin
        e.o[c] = f(md[c], n[c], e.t - base[c]);
        e.a[c] = 1'b1;
      end
    end
    sbq.push_back(e);
  endtask

  task automatic tick();
    exp_t e;
    push();
    @(posedge pl_clk);
    cyc++;
    #1;
    if (sbq.size() == 0) begin
      check("sb_empty", 32'd0, 32'd1);
    end else begin
      e = sbq.pop_front();
      check($sformatf("div_out@%0d", e.t), 32'(div_out), 32'(e.o));
      check($sformatf("active@%0d", e.t), 32'(active), 32'(e.a));
    end
  endtask

  task automatic do_reset();
    pl_resetn = 1'b0;
    cfg_valid = 1'b0;
    sync_restart = 1'b0;
    cfg_ch = '0;
    for (int c = 0; c < NC; c++) begin
      on[c] = 1'b0;
      sw_t[c] = -1;
    end
    #2;
    check("rst_div_out", 32'(div_out), 32'd0);
    check("rst_active", 32'(active), 32'd0);
    check("rst_ready", 32'(cfg_ready), 32'd1);
    #4;
    pl_resetn = 1'b1;
  endtask

  task automatic cfg_idle(input int ch, input int dv, input bit m);
    cfg_valid = 1'b1;
    cfg_ch = CW'(ch);
    cfg_div = W'(dv);
    cfg_mode = m;
    base[ch] = cyc + 1;
    n[ch] = dv;
    md[ch] = m;
    on[ch] = dv != 0;
    tick();
    cfg_valid = 1'b0;
  endtask

  task automatic cfg_pend(input int ch, input int dv, input bit m, input int t_sw, input bit o_sw);
    cfg_valid = 1'b1;
    cfg_ch = CW'(ch);
    cfg_div = W'(dv);
    cfg_mode = m;
    sw_t[ch] = t_sw;
    sw_n[ch] = dv;
    sw_m[ch] = m;
    sw_o[ch] = o_sw;
    tick();
    cfg_valid = 1'b0;
  endtask

  initial begin
    int b;
    for (int c = 0; c < NC; c++) sw_t[c] = -1;
    @(posedge pl_clk);
    #1;
    do_reset();
    cfg_idle(0, 3, 1'b0);
    repeat (14) tick();

    do_reset();
    cfg_idle(1, 4, 1'b1);
    b = cyc;
    tick();
    cfg_ch = CW'(1);
    #1;
    check("ready_run_ch1", 32'(cfg_ready), 32'd1);
    cfg_pend(1, 2, 1'b1, b + 4, 1'b1);
    check("ready_pend_a", 32'(cfg_ready), 32'd0);
    tick();
    check("ready_pend_b", 32'(cfg_ready), 32'd0);
    tick();
    check("ready_after_term", 32'(cfg_ready), 32'd1);
    repeat (8) tick();

    do_reset();
    cfg_idle(0, 5, 1'b0);
    cfg_idle(2, 7, 1'b0);
    repeat (6) tick();
    sync_restart = 1'b1;
    base[0] = cyc + 1;
    base[2] = cyc + 1;
    tick();
    sync_restart = 1'b0;
    repeat (16) tick();

    do_reset();
    cfg_idle(0, 3, 1'b0);
    cfg_idle(3, 3, 1'b0);
    cfg_pend(3, 0, 1'b0, -1, 1'b0);
    check("ready_pend_ch3", 32'(cfg_ready), 32'd0);
    cfg_valid = 1'b1;
    cfg_ch = CW'(0);
    cfg_div = W'(2);
    cfg_mode = 1'b1;
    sync_restart = 1'b1;
    #1;
    check("ready_sync_ch0", 32'(cfg_ready), 32'd1);
    base[0] = cyc + 1;
    n[0] = 2;
    md[0] = 1'b1;
    on[3] = 1'b0;
    tick();
    cfg_valid = 1'b0;
    sync_restart = 1'b0;
    cfg_ch = CW'(3);
    #1;
    check("ready_ch3_idle", 32'(cfg_ready), 32'd1);
    repeat (8) tick();

    cfg_valid = 1'b1;
    cfg_ch = CW'(5);
    cfg_div = W'(3);
    cfg_mode = 1'b0;
    #1;
    check("ready_oob5", 32'(cfg_ready), 32'd1);
    repeat (3) tick();
    cfg_ch = CW'(7);
    #1;
    check("ready_oob7", 32'(cfg_ready), 32'd1);
    repeat (3) tick();
    cfg_valid = 1'b0;

    do_reset();
    cfg_idle(1, 3, 1'b0);
    b = cyc;
    cfg_idle(2, 1, 1'b1);
    cfg_idle(4, 15, 1'b0);
    tick();
    tick();
    cfg_pend(1, 2, 1'b1, b + 6, 1'b0);
    repeat (30) tick();

    cfg_idle(0, 4, 1'b0);
    tick();
    cfg_pend(0, 6, 1'b0, -1, 1'b0);
    #2;
    pl_resetn = 1'b0;
    #1;
    check("mid_rst_div_out", 32'(div_out), 32'd0);
    check("mid_rst_active", 32'(active), 32'd0);
    for (int c = 0; c < NC; c++) begin
      on[c] = 1'b0;
      sw_t[c] = -1;
    end
    #2;
    pl_resetn = 1'b1;
    cfg_ch = CW'(0);
    #1;
    check("ready_after_rst", 32'(cfg_ready), 32'd1);
    repeat (8) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout cycle=%0d", cyc);
    $fatal(1, "timeout");
  end
endmodule
